seq_arith_unit: RTL and testbench

Parametrised, multi-cycle successor to the 4-bit synchronous arithmetic unit. It executes signed two's-complement operations on M-bit operands. Single-cycle ops (add, sub, set-less-than, abs) complete in one cycle. Multiply, divide and remainder run iteratively over M cycles. A start/busy/done handshake lets a sequencer or register-file front end issue one operation at a time and collect a registered result plus a 4-bit status word.

---
 rtl/seq_arith_unit.sv | 177 +++++++++++++++++
 tb/tb_seq_arith_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Signed M-bit arithmetic unit: ADD/SUB/SLT/ABS finish in one cycle; MUL/DIV/REM iterate for M cycles.
// Results and status are registered and held. o_done pulses for one cycle on each completion.
module seq_arith_unit #(
   parameter int N = 3,
   parameter int M = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [N-1:0] i_op,
   input  logic [M-1:0] i_arg_A,
   input  logic [M-1:0] i_arg_B,
   output logic         o_busy,
   output logic         o_done,
   output logic [M-1:0] o_result,
   output logic [3:0]   o_status
);

   localparam int CW = $clog2(M + 1);

   localparam logic [N-1:0] OP_ADD  = N'(0);
   localparam logic [N-1:0] OP_SUB  = N'(1);
   localparam logic [N-1:0] OP_SLT  = N'(2);
   localparam logic [N-1:0] OP_ABS  = N'(3);
   localparam logic [N-1:0] OP_MUL  = N'(4);
   localparam logic [N-1:0] OP_DIV  = N'(5);
   localparam logic [N-1:0] OP_REM  = N'(6);
   localparam logic [N-1:0] OP_RSVD = N'(7);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;

   // Iterative datapath: wq is the multiplier (shifting right) or the dividend/quotient (shifting left)
   logic            is_mul, is_rem, neg_res, neg_a;
   logic [M-1:0]    wq;
   logic [2*M-1:0]  acc, mcand;
   logic [M:0]      rem_r, dvsr;

   logic            accept, is_iter, is_err, go_run;
   logic [M:0]      a_ext, b_ext, mag_a, mag_b;
   logic [M-1:0]    sum, diff, sc_res;
   logic            sc_ovf;

   logic [2*M-1:0]  acc_nxt, prod;
   logic [M:0]      r_sh, r_nxt;
   logic            r_ge;
   logic [M-1:0]    q_nxt, fin_res;
   logic            fin_ovf;

   function automatic logic [3:0] mk_status(input logic [M-1:0] r, input logic ovf);
      return {1'b0, (r == '0), ovf, r[M-1]};
   endfunction

   // Operand decode and magnitudes (M+1 bits so that -2^(M-1) has a representable magnitude)
   always_comb begin
      accept  = (state == IDLE) && i_start;
      is_iter = (i_op == OP_MUL) || (i_op == OP_DIV) || (i_op == OP_REM);
      is_err  = (i_op >= OP_RSVD) ||
                (((i_op == OP_DIV) || (i_op == OP_REM)) && (i_arg_B == '0));
      go_run  = accept && is_iter && !is_err;
      a_ext   = {i_arg_A[M-1], i_arg_A};
      b_ext   = {i_arg_B[M-1], i_arg_B};
      mag_a   = i_arg_A[M-1] ? (~a_ext + (M+1)'(1)) : a_ext;
      mag_b   = i_arg_B[M-1] ? (~b_ext + (M+1)'(1)) : b_ext;
   end

   always_comb begin
      sum    = i_arg_A + i_arg_B;
      diff   = i_arg_A - i_arg_B;
      sc_res = '0;
      sc_ovf = 1'b0;
      case (i_op)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (i_arg_A[M-1] == i_arg_B[M-1]) && (sum[M-1] != i_arg_A[M-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (i_arg_A[M-1] != i_arg_B[M-1]) && (diff[M-1] != i_arg_A[M-1]);
         end
         OP_SLT: sc_res = {{(M-1){1'b0}}, ($signed(i_arg_A) < $signed(i_arg_B))};
         OP_ABS: begin
            sc_res = mag_a[M-1:0];
            sc_ovf = mag_a[M-1];
         end
         default: ;
      endcase
   end

   // One shift-add / restoring-division step, plus sign application for the final step
   always_comb begin
      acc_nxt = acc + (wq[0] ? mcand : '0);
      r_sh    = (rem_r << 1) | {{M{1'b0}}, wq[M-1]};
      r_ge    = (r_sh >= dvsr);
      r_nxt   = r_ge ? (r_sh - dvsr) : r_sh;
      q_nxt   = {wq[M-2:0], r_ge};
      prod    = neg_res ? (~acc_nxt + (2*M)'(1)) : acc_nxt;
      if (is_mul) begin
         fin_res = prod[M-1:0];
         fin_ovf = (prod[2*M-1:M-1] != '0) && (prod[2*M-1:M-1] != '1);
      end else if (is_rem) begin
         fin_res = neg_a ? (~r_nxt[M-1:0] + M'(1)) : r_nxt[M-1:0];
         fin_ovf = 1'b0;
      end else begin
         fin_res = neg_res ? (~q_nxt + M'(1)) : q_nxt;
         fin_ovf = !neg_res && q_nxt[M-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (go_run) state_nxt = RUN;
         RUN:  if (cnt == CW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == RUN);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt      <= '0;
         o_done   <= 1'b0;
         o_result <= '0;
         o_status <= 4'b0000;
         is_mul   <= 1'b0;
         is_rem   <= 1'b0;
         neg_res  <= 1'b0;
         neg_a    <= 1'b0;
         wq       <= '0;
         acc      <= '0;
         mcand    <= '0;
         rem_r    <= '0;
         dvsr     <= '0;
      end else begin
         o_done <= 1'b0;
         if (go_run) begin
            cnt     <= CW'(M);
            is_mul  <= (i_op == OP_MUL);
            is_rem  <= (i_op == OP_REM);
            neg_res <= i_arg_A[M-1] ^ i_arg_B[M-1];
            neg_a   <= i_arg_A[M-1];
            wq      <= (i_op == OP_MUL) ? mag_b[M-1:0] : mag_a[M-1:0];
            mcand   <= {{(M-1){1'b0}}, mag_a};
            acc     <= '0;
            rem_r   <= '0;
            dvsr    <= mag_b;
         end else if (accept) begin
            o_done   <= 1'b1;
            o_result <= is_err ? '0 : sc_res;
            o_status <= is_err ? 4'b1000 : mk_status(sc_res, sc_ovf);
         end else if (state == RUN) begin
            cnt   <= cnt - CW'(1);
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            rem_r <= r_nxt;
            wq    <= is_mul ? (wq >> 1) : q_nxt;
            if (cnt == CW'(1)) begin
               o_done   <= 1'b1;
               o_result <= fin_res;
               o_status <= mk_status(fin_res, fin_ovf);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (M=8, N=3) with hand-computed expected values.
module tb_seq_arith_unit;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_start = 1'b0;
   logic [2:0] i_op = 3'd0;
   logic [7:0] i_arg_A = 8'd0;
   logic [7:0] i_arg_B = 8'd0;
   logic       o_busy, o_done;
   logic [7:0] o_result;
   logic [3:0] o_status;

   int errors = 0;
   int checks = 0;

   seq_arith_unit #(.N(3), .M(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
      .i_arg_A(i_arg_A), .i_arg_B(i_arg_B), .o_busy(o_busy), .o_done(o_done),
      .o_result(o_result), .o_status(o_status)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Single-cycle issue: outputs sampled just after the accepting edge k.
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      i_op = op; i_arg_A = a; i_arg_B = b; i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Iterative issue: returns edges from acceptance to done (-1 on timeout) and cycles with busy high.
   task automatic do_iter(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bcnt);
      do_op(op, a, b);
      lat  = -1;
      bcnt = o_busy ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (o_done) begin
            lat = i;
            break;
         end
         if (o_busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      tick();
      tick();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", o_status); end
      i_reset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_op(3'b000, 8'd100, 8'd50);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", o_done); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b expected 0", o_busy); end
      checks++; if (o_result !== 8'h96) begin errors++; $display("FAIL add_result: got %h expected 96", o_result); end
      checks++; if (o_status !== 4'b0011) begin errors++; $display("FAIL add_status: got %b expected 0011", o_status); end
      do_op(3'b001, 8'd3, 8'd3);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL sub_done: got %b expected 1", o_done); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL sub_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b0100) begin errors++; $display("FAIL sub_status: got %b expected 0100", o_status); end
      tick();
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL sub_done_drop: got %b expected 0", o_done); end
      checks++; if (o_status !== 4'b0100) begin errors++; $display("FAIL sub_status_held: got %b expected 0100", o_status); end
   endtask

   task automatic test_mul();
      int lat, bcnt;
      do_iter(3'b100, 8'hF9, 8'd6, lat, bcnt);
      checks++; if (lat !== 8) begin errors++; $display("FAIL mul_latency: got %0d expected 8", lat); end
      checks++; if (bcnt !== 8) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 8", bcnt); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done: got %b expected 0", o_busy); end
      checks++; if (o_result !== 8'hD6) begin errors++; $display("FAIL mul_result: got %h expected d6", o_result); end
      checks++; if (o_status !== 4'b0001) begin errors++; $display("FAIL mul_status: got %b expected 0001", o_status); end
      tick();
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b expected 0", o_done); end
      do_iter(3'b100, 8'd16, 8'd16, lat, bcnt);
      checks++; if (lat !== 8) begin errors++; $display("FAIL mul16_latency: got %0d expected 8", lat); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL mul16_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b0110) begin errors++; $display("FAIL mul16_status: got %b expected 0110", o_status); end
      tick();
   endtask

   task automatic test_div();
      int lat, bcnt;
      do_iter(3'b101, 8'hF9, 8'd2, lat, bcnt);
      checks++; if (lat !== 8) begin errors++; $display("FAIL div_latency: got %0d expected 8", lat); end
      checks++; if (o_result !== 8'hFD) begin errors++; $display("FAIL div_result: got %h expected fd", o_result); end
      checks++; if (o_status !== 4'b0001) begin errors++; $display("FAIL div_status: got %b expected 0001", o_status); end
      tick();
      do_iter(3'b110, 8'hF9, 8'd2, lat, bcnt);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rem_latency: got %0d expected 8", lat); end
      checks++; if (o_result !== 8'hFF) begin errors++; $display("FAIL rem_result: got %h expected ff", o_result); end
      checks++; if (o_status !== 4'b0001) begin errors++; $display("FAIL rem_status: got %b expected 0001", o_status); end
      tick();
      do_iter(3'b101, 8'h80, 8'hFF, lat, bcnt);
      checks++; if (o_result !== 8'h80) begin errors++; $display("FAIL divmin_result: got %h expected 80", o_result); end
      checks++; if (o_status !== 4'b0011) begin errors++; $display("FAIL divmin_status: got %b expected 0011", o_status); end
      tick();
      do_iter(3'b110, 8'd17, 8'hFB, lat, bcnt);
      checks++; if (o_result !== 8'h02) begin errors++; $display("FAIL rem_pos_result: got %h expected 02", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL rem_pos_status: got %b expected 0000", o_status); end
      tick();
   endtask

   task automatic test_errors();
      do_op(3'b101, 8'd5, 8'd0);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL divzero_done: got %b expected 1", o_done); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL divzero_busy: got %b expected 0", o_busy); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL divzero_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b1000) begin errors++; $display("FAIL divzero_status: got %b expected 1000", o_status); end
      do_op(3'b111, 8'd9, 8'd4);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rsvd_done: got %b expected 1", o_done); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy: got %b expected 0", o_busy); end
      checks++; if (o_status !== 4'b1000) begin errors++; $display("FAIL rsvd_status: got %b expected 1000", o_status); end
      tick();
   endtask

   task automatic test_ignore_and_abort();
      int lat;
      lat = -1;
      do_op(3'b100, 8'd3, 8'd5);
      tick();
      tick();
      i_op = 3'b000; i_arg_A = 8'd100; i_arg_B = 8'd100; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL ignore_no_done: got %b expected 0", o_done); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", o_busy); end
      for (int i = 4; i <= 20; i++) begin
         tick();
         if (o_done) begin
            lat = i;
            break;
         end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
      checks++; if (o_result !== 8'h0F) begin errors++; $display("FAIL ignore_result: got %h expected 0f", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL ignore_status: got %b expected 0000", o_status); end
      tick();
      do_op(3'b100, 8'd3, 8'd5);
      tick();
      tick();
      tick();
      i_reset = 1'b1;
      tick();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", o_done); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL abort_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL abort_status: got %b expected 0000", o_status); end
      i_reset = 1'b0;
      do_op(3'b000, 8'd1, 8'd2);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL post_reset_done: got %b expected 1", o_done); end
      checks++; if (o_result !== 8'h03) begin errors++; $display("FAIL post_reset_result: got %h expected 03", o_result); end
      tick();
   endtask

   task automatic test_abs_slt();
      do_op(3'b011, 8'h80, 8'd0);
      checks++; if (o_result !== 8'h80) begin errors++; $display("FAIL absmin_result: got %h expected 80", o_result); end
      checks++; if (o_status !== 4'b0011) begin errors++; $display("FAIL absmin_status: got %b expected 0011", o_status); end
      do_op(3'b011, 8'hFB, 8'd0);
      checks++; if (o_result !== 8'h05) begin errors++; $display("FAIL abs5_result: got %h expected 05", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL abs5_status: got %b expected 0000", o_status); end
      do_op(3'b010, 8'hFC, 8'd3);
      checks++; if (o_result !== 8'h01) begin errors++; $display("FAIL slt_lt_result: got %h expected 01", o_result); end
      checks++; if (o_status !== 4'b0000) begin errors++; $display("FAIL slt_lt_status: got %b expected 0000", o_status); end
      do_op(3'b010, 8'd7, 8'd4);
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL slt_ge_result: got %h expected 00", o_result); end
      checks++; if (o_status !== 4'b0100) begin errors++; $display("FAIL slt_ge_status: got %b expected 0100", o_status); end
      do_op(3'b001, 8'h80, 8'd1);
      checks++; if (o_result !== 8'h7F) begin errors++; $display("FAIL sub_ovf_result: got %h expected 7f", o_result); end
      checks++; if (o_status !== 4'b0010) begin errors++; $display("FAIL sub_ovf_status: got %b expected 0010", o_status); end
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mul();
      test_div();
      test_errors();
      test_ignore_and_abort();
      test_abs_slt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
